// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock,
// with valid/ready handshakes on both sides and registered borrow/overflow/zero flags.
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         ovf,
    output logic         zero
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic [W-1:0]  diff_q, diff_d;
    logic          br_q, br_d;
    logic          a_sign_q, a_sign_d;
    logic          b_sign_q, b_sign_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          borrow_q, borrow_d;
    logic          ovf_q, ovf_d;
    logic          zero_q, zero_d;

    logic          d_bit;
    logic          br_next;
    logic [W:0]    res_ext;
    logic [W-1:0]  res_shift;

    always_comb begin
        d_bit     = a_q[0] ^ b_q[0] ^ br_q;
        br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        // Widening by one bit keeps the shift-in legal for W=1
        res_ext   = {d_bit, res_q};
        res_shift = res_ext[W:1];

        state_d     = state_q;
        count_d     = count_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        diff_d      = diff_q;
        br_d        = br_q;
        a_sign_d    = a_sign_q;
        b_sign_d    = b_sign_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    res_d      = '0;
                    br_d       = 1'b0;
                    count_d    = '0;
                    a_sign_d   = a[W-1];
                    b_sign_d   = b[W-1];
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                br_d    = br_next;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_shift;
                count_d = count_q + CW'(1);
                // Flags are latched from the final bit so diff stays stable between ops
                if (count_q == CW'(W - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    diff_d      = res_shift;
                    borrow_d    = br_next;
                    ovf_d       = (a_sign_q ^ b_sign_q) & (res_shift[W-1] ^ a_sign_q);
                    zero_d      = (res_shift == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            diff_q      <= '0;
            br_q        <= 1'b0;
            a_sign_q    <= 1'b0;
            b_sign_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            diff_q      <= diff_d;
            br_q        <= br_d;
            a_sign_q    <= a_sign_d;
            b_sign_q    <= b_sign_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: W=8 and W=1 instances, randomized operands
// compared against an integer-arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, diff;
    logic         borrow, ovf, zero;

    logic         in_valid1, in_ready1, out_valid1, out_ready1;
    logic [0:0]   a1, b1, diff1;
    logic         borrow1, ovf1, zero1;

    int checks = 0;
    int failures = 0;

    logic [15:0] pending[$];

    serial_subtractor #(.W(W)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .ovf(ovf), .zero(zero)
    );

    serial_subtractor #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .borrow(borrow1), .ovf(ovf1), .zero(zero1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction, signed range test for overflow
    function automatic void refModel(input int w, input int ua, input int ub,
                                     output int d, output int br, output int ov, output int z);
        int sa, sb, sd;
        d  = (ua - ub) & ((1 << w) - 1);
        br = (ua < ub) ? 1 : 0;
        sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        sd = sa - sb;
        ov = (sd > (1 << (w - 1)) - 1 || sd < -(1 << (w - 1))) ? 1 : 0;
        z  = (d == 0) ? 1 : 0;
    endfunction

    function automatic logic [7:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input int holdCycles,
                                 input string tag);
        int ed, eb, eo, ez, cycles;
        refModel(W, ta, tb, ed, eb, eo, ez);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_busy"}, in_ready, 0);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 4 * W) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, cycles, W);
        checkOutput({tag, "_diff"}, diff, ed);
        checkOutput({tag, "_borrow"}, borrow, eb);
        checkOutput({tag, "_ovf"}, ovf, eo);
        checkOutput({tag, "_zero"}, zero, ez);
        checkOutput({tag, "_rdy_done"}, in_ready, 0);
        for (int h = 0; h < holdCycles; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, out_valid, 1);
            checkOutput({tag, "_hold_diff"}, diff, ed);
            checkOutput({tag, "_hold_flags"}, {borrow, ovf, zero}, {eb[0], eo[0], ez[0]});
            checkOutput({tag, "_hold_rdy"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_drop_valid"}, out_valid, 0);
        checkOutput({tag, "_idle_rdy"}, in_ready, 1);
        checkOutput({tag, "_kept_diff"}, diff, ed);
        out_ready = 1'b0;
    endtask

    task automatic runOpW1(input logic ta, input logic tb, input string tag);
        int ed, eb, eo, ez, cycles;
        refModel(1, int'(ta), int'(tb), ed, eb, eo, ez);
        in_valid1 = 1'b1;
        a1        = ta;
        b1        = tb;
        @(negedge clk);
        in_valid1 = 1'b0;
        cycles = 0;
        while (out_valid1 !== 1'b1 && cycles < 8) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, cycles, 1);
        checkOutput({tag, "_diff"}, diff1, ed);
        checkOutput({tag, "_flags"}, {borrow1, ovf1, zero1}, {eb[0], eo[0], ez[0]});
        out_ready1 = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_drop_valid"}, out_valid1, 0);
        out_ready1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ed, eb, eo, ez, seen;
        logic [15:0] ent;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        a1         = '0;
        b1         = '0;
        out_ready1 = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_diff", diff, 0);
        checkOutput("rst_flags", {borrow, ovf, zero}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(8'h05, 8'h03, 0, "sub_05_03");
        applyStimulus(8'h03, 8'h05, 0, "sub_03_05");
        applyStimulus(8'h80, 8'h01, 0, "sub_80_01");
        applyStimulus(8'h7F, 8'hFF, 0, "sub_7F_FF");

        // Abort an operation mid-shift; previous result (0x80, borrow, ovf) must be cleared
        in_valid = 1'b1;
        a        = 8'h33;
        b        = 8'h11;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_in_ready", in_ready, 1);
        checkOutput("abort_diff", diff, 0);
        checkOutput("abort_flags", {borrow, ovf, zero}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_release_rdy", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checkOutput("abort_no_valid", seen, 0);

        applyStimulus(8'h5A, 8'h5A, 5, "hold_5A");

        // Back-to-back: one accept every W+2 cycles while in_valid/out_ready stay high
        out_ready = 1'b1;
        for (int k = 0; k < 4 * (W + 2); k++) begin
            in_valid = 1'b1;
            a        = pickOperand();
            b        = pickOperand();
            if (k % (W + 2) == 0) pending.push_back({a, b});
            @(posedge clk);
            @(negedge clk);
            checkOutput("b2b_valid", out_valid, (k % (W + 2) == W) ? 1 : 0);
            checkOutput("b2b_ready", in_ready, (k % (W + 2) == W + 1) ? 1 : 0);
            if (out_valid === 1'b1) begin
                if (pending.size() == 0) begin
                    checkOutput("b2b_order", out_valid, 0);
                end else begin
                    ent = pending.pop_front();
                    refModel(W, ent[15:8], ent[7:0], ed, eb, eo, ez);
                    checkOutput("b2b_diff", diff, ed);
                    checkOutput("b2b_flags", {borrow, ovf, zero}, {eb[0], eo[0], ez[0]});
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 24; r++) begin
            applyStimulus(pickOperand(), pickOperand(), (r % 4 == 0) ? 2 : 0, "rand");
        end

        runOpW1(1'b0, 1'b1, "w1_0_1");
        runOpW1(1'b1, 1'b1, "w1_1_1");
        runOpW1(1'b1, 1'b0, "w1_1_0");
        runOpW1(1'b0, 1'b0, "w1_0_0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
